// File: rtl/a_ctrls_pkg.sv
// Shared types and defaults for the analog-control frame decoder and encoder.
package a_ctrls_pkg;

    typedef enum logic [3:0] {
        IDLE, HDR1, HDR2, HDR3, SEP_W, HI, LO, CK_SEP, CK_HI, CK_LO
    } dec_state_t;

    // Encodings are visible on err_code, so they are pinned explicitly.
    typedef enum logic [1:0] {
        ERR_SEP   = 2'd0,
        ERR_HEX   = 2'd1,
        ERR_CKSUM = 2'd2,
        ERR_TMO   = 2'd3
    } dec_err_t;

    localparam logic [31:0] DEF_HEADER = 32'h4D45_4153; // "MEAS"
    localparam logic [7:0]  DEF_SEP    = 8'h3A;         // ":"

endpackage

// File: rtl/a_ctrls_hex_nibble.sv
// ASCII hex digit to nibble; shared with the TX-side encoder.
module a_ctrls_hex_nibble (
    input  logic [7:0] char_i,
    output logic [3:0] nibble_o,
    output logic       is_hex_o
);

    // Digits map straight from the low nibble; letters sit 9 below their value.
    always_comb begin
        nibble_o = 4'h0;
        is_hex_o = 1'b0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            nibble_o = char_i[3:0];
            is_hex_o = 1'b1;
        end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                     (char_i >= 8'h61 && char_i <= 8'h66)) begin
            nibble_o = char_i[3:0] + 4'd9;
            is_hex_o = 1'b1;
        end
    end

endmodule

// File: rtl/a_ctrls_frame_decoder.sv
// Decodes "HDR:hh:hh...:cc" ASCII frames; commits the value bank only on a
// fully valid frame, otherwise reports the abort cause.
module a_ctrls_frame_decoder
    import a_ctrls_pkg::*;
#(
    parameter int unsigned N_VALUES    = 7,
    parameter logic [31:0] HEADER      = DEF_HEADER,
    parameter logic [7:0]  SEP         = DEF_SEP,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic [7:0] values [0:N_VALUES-1],
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int unsigned IDX_W = (N_VALUES > 1) ? $clog2(N_VALUES) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    dec_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic [3:0]       hi_q, hi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shadow_q [0:N_VALUES-1];
    logic [7:0]       values_q [0:N_VALUES-1];
    logic             ok_q, err_q;
    dec_err_t         code_q;

    logic             shadow_we, commit, abort;
    dec_err_t         abort_code;
    logic [3:0]       nib;
    logic             is_hex;
    logic [7:0]       byte_val;

    a_ctrls_hex_nibble u_hex (
        .char_i   (data_in),
        .nibble_o (nib),
        .is_hex_o (is_hex)
    );

    assign byte_val = {hi_q, nib};

    // Next-state, datapath enables and abort detection.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        hi_d       = hi_q;
        shadow_we  = 1'b0;
        commit     = 1'b0;
        abort      = 1'b0;
        abort_code = ERR_SEP;
        if (data_valid) begin
            unique case (state_q)
                IDLE: if (data_in == HEADER[31:24]) state_d = HDR1;
                HDR1: if (data_in == HEADER[23:16])     state_d = HDR2;
                      else if (data_in == HEADER[31:24]) state_d = HDR1;
                      else                               state_d = IDLE;
                HDR2: if (data_in == HEADER[15:8])      state_d = HDR3;
                      else if (data_in == HEADER[31:24]) state_d = HDR1;
                      else                               state_d = IDLE;
                HDR3: if (data_in == HEADER[7:0]) begin
                          state_d = SEP_W;
                          idx_d   = '0;
                          sum_d   = 8'h00;
                      end else if (data_in == HEADER[31:24]) state_d = HDR1;
                      else                                    state_d = IDLE;
                SEP_W, CK_SEP: begin
                    if (data_in != SEP) begin
                        abort      = 1'b1;
                        abort_code = ERR_SEP;
                    end else begin
                        state_d = (state_q == SEP_W) ? HI : CK_HI;
                    end
                end
                HI, CK_HI: begin
                    if (!is_hex) begin
                        abort      = 1'b1;
                        abort_code = ERR_HEX;
                    end else begin
                        hi_d    = nib;
                        state_d = (state_q == HI) ? LO : CK_LO;
                    end
                end
                LO: begin
                    if (!is_hex) begin
                        abort      = 1'b1;
                        abort_code = ERR_HEX;
                    end else begin
                        shadow_we = 1'b1;
                        sum_d     = sum_q + byte_val;
                        if (idx_q == IDX_W'(N_VALUES - 1)) begin
                            state_d = CK_SEP;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = SEP_W;
                        end
                    end
                end
                CK_LO: begin
                    state_d = IDLE;
                    if (!is_hex) begin
                        abort      = 1'b1;
                        abort_code = ERR_HEX;
                    end else if (byte_val == sum_q) begin
                        commit = 1'b1;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ERR_CKSUM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            // The edge that would take the count to TIMEOUT_CYC aborts instead.
            abort      = 1'b1;
            abort_code = ERR_TMO;
        end
        if (abort) state_d = IDLE;
    end

    // Idle-gap counter: any strobe or being in IDLE restarts it.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (data_valid || state_q == IDLE || abort) cnt_d = '0;
    end

    // Control state, status pulses and the sticky error code.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sum_q   <= 8'h00;
            hi_q    <= 4'h0;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_SEP;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            ok_q    <= commit;
            err_q   <= abort;
            if (abort) code_q <= abort_code;
        end
    end

    // Shadow bank collects a frame; the visible bank copies it in one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_VALUES; i++) begin
                shadow_q[i] <= 8'h00;
                values_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < N_VALUES; i++) begin
                if (shadow_we && idx_q == IDX_W'(i)) shadow_q[i] <= byte_val;
                if (commit) values_q[i] <= shadow_q[i];
            end
        end
    end

    assign values    = values_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_a_ctrls_frame_decoder.sv
// Directed bench: a 7-value decoder and a 1-value decoder share clock/reset;
// expected frame events are queued at stimulus time and matched on output.
module tb_a_ctrls_frame_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] d7, d1;
    logic       dv7, dv1;
    logic [7:0] values7 [0:6];
    logic [7:0] values1 [0:0];
    logic       ok7, err7, busy7, ok1, err1, busy1;
    logic [1:0] code7, code1;
    logic [55:0] v7;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        bit          ok;
        logic [1:0]  code;
        logic [55:0] bank;
        int          cyc;
    } evt_t;
    evt_t sb[$];
    evt_t e;

    localparam logic [55:0] BANK_A = {8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    localparam logic [55:0] BANK_B = {8'h0A, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

    a_ctrls_frame_decoder #(.N_VALUES(7), .TIMEOUT_CYC(16)) dut7 (
        .clk(clk), .reset_n(reset_n), .data_in(d7), .data_valid(dv7),
        .values(values7), .frame_ok(ok7), .frame_err(err7),
        .err_code(code7), .busy(busy7)
    );

    a_ctrls_frame_decoder #(.N_VALUES(1), .TIMEOUT_CYC(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .data_in(d1), .data_valid(dv1),
        .values(values1), .frame_ok(ok1), .frame_err(err1),
        .err_code(code1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        v7 = '0;
        for (int i = 0; i < 7; i++) v7[i*8 +: 8] = values7[i];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte i of the next send is consumed at the edge that makes cyc = now+i+1.
    task automatic expect_evt(input bit ok, input logic [1:0] code,
                              input logic [55:0] bank, input int off);
        evt_t x;
        x.ok = ok; x.code = code; x.bank = bank; x.cyc = cyc + off;
        sb.push_back(x);
    endtask

    task automatic send_str(input string s, input bit to_one);
        for (int i = 0; i < s.len(); i++) begin
            if (to_one) begin d1 = s[i]; dv1 = 1'b1; end
            else        begin d7 = s[i]; dv7 = 1'b1; end
            @(posedge clk); #1;
        end
        dv7 = 1'b0;
        dv1 = 1'b0;
    endtask

    task automatic frame7(input string s, input bit ok, input logic [1:0] code,
                          input logic [55:0] bank);
        expect_evt(ok, code, bank, s.len());
        send_str(s, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every pulse on the 7-value decoder must match the queue head.
    always @(negedge clk) begin
        if (reset_n && (ok7 || err7)) begin
            chk("ok_err_exclusive", {63'd0, ok7 & err7}, 64'd0);
            chk("event_expected", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("event_kind_ok", {63'd0, ok7}, {63'd0, e.ok});
                chk("event_cycle", cyc, e.cyc);
                chk("event_values", v7, e.bank);
                if (!e.ok) chk("event_err_code", code7, e.code);
            end
        end
    end

    initial begin
        string rest;
        reset_n = 1'b0;
        d7 = 8'h00; d1 = 8'h00; dv7 = 1'b0; dv1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_values", v7, 56'd0);
        chk("reset_pulses", {ok7, err7, busy7}, 3'b000);
        chk("reset_err_code", code7, 2'd0);
        reset_n = 1'b1;
        idle(2);

        // Two valid frames back to back, second uses lowercase hex.
        frame7("MEAS:01:02:03:04:05:06:07:1C", 1'b1, 2'd0, BANK_A);
        frame7("MEAS:01:02:03:04:05:06:0a:1f", 1'b1, 2'd0, BANK_B);
        idle(2);
        chk("lowercase_value6", values7[6], 8'h0A);

        // Checksum mismatch keeps the previous bank.
        frame7("MEAS:01:02:03:04:05:06:07:1D", 1'b0, 2'd2, BANK_B);
        idle(2);
        chk("cksum_bank_kept", v7, BANK_B);
        chk("cksum_err_code", code7, 2'd2);

        // Bad hex, then resync through a doubled header character.
        frame7("MEAS:0G", 1'b0, 2'd1, BANK_B);
        frame7("MMEAS:01:02:03:04:05:06:07:1C", 1'b1, 2'd0, BANK_A);
        idle(2);
        chk("err_code_held_after_ok", code7, 2'd1);

        // Wrong separator before a value.
        frame7("MEAS;", 1'b0, 2'd0, BANK_A);
        idle(2);

        // Stall mid-frame: abort lands exactly TIMEOUT_CYC edges after the last byte.
        expect_evt(1'b0, 2'd3, BANK_A, 6 + 16);
        send_str("MEAS:0", 1'b0);
        chk("busy_mid_frame", {63'd0, busy7}, 64'd1);
        idle(20);
        chk("busy_after_timeout", {63'd0, busy7}, 64'd0);
        chk("timeout_err_code", code7, 2'd3);

        // A strobe on the would-be timeout edge is consumed normally.
        send_str("MEAS:0", 1'b0);
        idle(15);
        rest = "1:02:03:04:05:06:0a:1f";
        frame7(rest, 1'b1, 2'd0, BANK_B);
        idle(2);
        chk("late_strobe_bank", v7, BANK_B);

        // Single-value decoder with strobes every cycle.
        send_str("MEAS:FF:FF", 1'b1);
        chk("n1_frame_ok", {ok1, err1}, 2'b10);
        chk("n1_value", values1[0], 8'hFF);
        send_str("MEAS:F", 1'b1);
        chk("n1_ok_one_cycle", {63'd0, ok1}, 64'd0);
        chk("n1_busy_mid", {63'd0, busy1}, 64'd1);

        // Asynchronous reset mid-frame, away from any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_n1_value", values1[0], 8'h00);
        chk("rst_n1_status", {ok1, err1, busy1, code1}, 5'd0);
        chk("rst_n7_values", v7, 56'd0);
        chk("rst_n7_code", code7, 2'd0);
        idle(2);

        chk("scoreboard_drained", sb.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
